// File: rtl/bus_master_030.sv
// ---------------------------------------------------------------------------
// bus_master_030
//
// Purpose:
//   Synchronous initiator for an MC68030-style asynchronous bus. A client
//   (DMA engine, test stimulus, ...) hands over one operand of 1-4 bytes. The
//   master runs one or more bus cycles until the whole operand has moved.
//   Each cycle ends on DSACK1:0, and the acknowledge code tells the master
//   the width of the responding port (dynamic bus sizing). Misaligned
//   operands and operands wider than the port are split into several cycles
//   automatically. The master finishes with a one-clock DONE pulse that
//   carries read data and the error status.
//
// Ports:
//   CLK, RST_n          clock (posedge) and synchronous active-low reset
//   REQ, REQ_WE,        client request: strobe, write flag, byte address,
//   REQ_ADDR, REQ_LEN,  length (00=4, 01=1, 10=2, 11=3) and right-justified
//   REQ_WDATA           write operand
//   BUSY, DONE          busy from acceptance until DONE; DONE is a 1-clock pulse
//   RDATA               right-justified read operand, valid with DONE
//   ERR_BERR,           valid with DONE: bus error / no termination in time
//   ERR_TIMEOUT
//   ADDR, RW, SIZ1:0    bus address, direction (1 = read), remaining bytes
//   AS_n, DS_n          address and data strobes
//   DATA_OUT, DATA_OE   write data on D31:0 and its drive enable
//   DATA_IN             read data from D31:0 (lane 0 = D31:24)
//   DSACK0_n, DSACK1_n, asynchronous cycle terminations from the responder
//   BERR_n
// ---------------------------------------------------------------------------
module bus_master_030 #(
  parameter int ADDR_W         = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              REQ,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [1:0]        REQ_LEN,
  input  logic [31:0]       REQ_WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [31:0]       RDATA,
  output logic              ERR_BERR,
  output logic              ERR_TIMEOUT,
  output logic [ADDR_W-1:0] ADDR,
  output logic              RW,
  output logic              SIZ0,
  output logic              SIZ1,
  output logic              AS_n,
  output logic              DS_n,
  output logic [31:0]       DATA_OUT,
  output logic              DATA_OE,
  input  logic [31:0]       DATA_IN,
  input  logic              DSACK0_n,
  input  logic              DSACK1_n,
  input  logic              BERR_n
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_WAIT,
    ST_LATCH,
    ST_END,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;

  // Transfer context. op_q holds the operand bytes still to be written,
  // left-justified, so op byte 0 is always op_q[31:24].
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        rem_q;
  logic              we_q;
  logic [31:0]       op_q;
  logic [31:0]       acc_q;
  logic              berr_q;
  logic              tmo_q;
  logic [CNT_W-1:0]  cnt_q;

  // Two-flop synchronizers for the asynchronous terminations
  logic dsack0_m, dsack0_s;
  logic dsack1_m, dsack1_s;
  logic berr_m,   berr_s;

  // Request decode
  logic [2:0]  req_rem;
  logic [31:0] req_op;

  // Per-cycle transfer arithmetic
  logic [1:0]        lane_a;
  logic [2:0]        room;
  logic [2:0]        take;
  logic [1:0]        start_lane;
  logic [31:0]       rd_shifted;
  logic [31:0]       rd_bytes;
  logic [31:0]       acc_next;
  logic [31:0]       op_next;
  logic [ADDR_W-1:0] addr_next;
  logic [2:0]        rem_next;
  logic [31:0]       wr_lanes;

  // Termination qualifiers evaluated in WAIT
  logic berr_hit, ack_hit, tmo_hit, bus_quiet;

  // FSM-decoded bus controls
  logic as_n_c, ds_n_c, rw_c, oe_c, busy_c, done_c;

  // Synchronize DSACK0_n, DSACK1_n and BERR_n; idle value is negated (high)
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      dsack0_m <= 1'b1;
      dsack0_s <= 1'b1;
      dsack1_m <= 1'b1;
      dsack1_s <= 1'b1;
      berr_m   <= 1'b1;
      berr_s   <= 1'b1;
    end else begin
      dsack0_m <= DSACK0_n;
      dsack0_s <= dsack0_m;
      dsack1_m <= DSACK1_n;
      dsack1_s <= dsack1_m;
      berr_m   <= BERR_n;
      berr_s   <= berr_m;
    end
  end

  // Request length uses SIZ encoding (00 means four bytes). The operand is
  // left-justified so the most significant remaining byte sits in op byte 0.
  always_comb begin
    req_rem = (REQ_LEN == 2'b00) ? 3'd4 : {1'b0, REQ_LEN};
    req_op  = REQ_WDATA << {3'd4 - req_rem, 3'b000};
  end

  // Port size from the synchronized acknowledge code decides how many bytes
  // this cycle moved and which lanes they occupied. A 16-bit port sits on
  // D31:16 and an 8-bit port on D31:24, so their start lane ignores the
  // upper address bits.
  always_comb begin
    lane_a     = addr_q[1:0];
    room       = 3'd1;
    start_lane = 2'd0;
    case ({dsack1_s, dsack0_s})
      2'b00: begin
        room       = 3'd4 - {1'b0, lane_a};
        start_lane = lane_a;
      end
      2'b01: begin
        room       = 3'd2 - {2'b00, lane_a[0]};
        start_lane = {1'b0, lane_a[0]};
      end
      default: begin
        room       = 3'd1;
        start_lane = 2'd0;
      end
    endcase
    take = (room < rem_q) ? room : rem_q;

    // Slide the first valid lane up to D31:24, then right-justify the
    // 'take' bytes so they can be appended to the accumulator.
    rd_shifted = DATA_IN << {start_lane, 3'b000};
    rd_bytes   = rd_shifted >> {3'd4 - take, 3'b000};
    acc_next   = (acc_q << {take, 3'b000}) | rd_bytes;
    op_next    = op_q << {take, 3'b000};
    addr_next  = addr_q + {{(ADDR_W-3){1'b0}}, take};
    rem_next   = rem_q - take;
  end

  // Write lane steering. Lanes at or after the address offset carry the
  // operand in order; lanes before it replicate the leading bytes so that an
  // 8-bit port (lane 0) or a 16-bit port (lanes 0-1) still picks up the
  // right bytes whatever the offset.
  always_comb begin
    case (lane_a)
      2'd0:    wr_lanes = {op_q[31:24], op_q[23:16], op_q[15:8],  op_q[7:0]};
      2'd1:    wr_lanes = {op_q[31:24], op_q[31:24], op_q[23:16], op_q[15:8]};
      2'd2:    wr_lanes = {op_q[31:24], op_q[23:16], op_q[31:24], op_q[23:16]};
      default: wr_lanes = {op_q[31:24], op_q[31:24], op_q[31:24], op_q[31:24]};
    endcase
  end

  // Termination qualifiers. BERR outranks DSACK when both arrive together.
  always_comb begin
    berr_hit  = !berr_s;
    ack_hit   = !dsack0_s || !dsack1_s;
    tmo_hit   = (cnt_q == CNT_LAST);
    bus_quiet = dsack0_s && dsack1_s && berr_s;
  end

  // Next-state and bus control decode
  always_comb begin
    state_d = state_q;
    as_n_c  = 1'b1;
    ds_n_c  = 1'b1;
    rw_c    = 1'b1;
    oe_c    = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        busy_c  = 1'b1;
        rw_c    = !we_q;
        oe_c    = we_q;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        // Reads assert DS together with AS; writes give the data a clock
        // of setup first.
        busy_c  = 1'b1;
        rw_c    = !we_q;
        oe_c    = we_q;
        as_n_c  = 1'b0;
        ds_n_c  = we_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy_c = 1'b1;
        rw_c   = !we_q;
        oe_c   = we_q;
        as_n_c = 1'b0;
        ds_n_c = 1'b0;
        if (berr_hit)     state_d = ST_END;
        else if (ack_hit) state_d = ST_LATCH;
        else if (tmo_hit) state_d = ST_END;
      end
      ST_LATCH: begin
        busy_c  = 1'b1;
        rw_c    = !we_q;
        oe_c    = we_q;
        as_n_c  = 1'b0;
        ds_n_c  = 1'b0;
        state_d = ST_END;
      end
      ST_END: begin
        // Strobes are negated; wait for the responder to release its
        // terminations before starting another cycle or finishing.
        busy_c = 1'b1;
        rw_c   = !we_q;
        if (bus_quiet) begin
          if (berr_q || tmo_q || rem_q == 3'd0) state_d = ST_DONE;
          else                                  state_d = ST_ADDR;
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and transfer datapath
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= 3'd0;
      we_q    <= 1'b0;
      op_q    <= 32'd0;
      acc_q   <= 32'd0;
      berr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            addr_q <= REQ_ADDR;
            rem_q  <= req_rem;
            we_q   <= REQ_WE;
            op_q   <= req_op;
            acc_q  <= 32'd0;
            berr_q <= 1'b0;
            tmo_q  <= 1'b0;
          end
        end
        ST_STROBE: begin
          cnt_q <= '0;
        end
        ST_WAIT: begin
          if (berr_hit) begin
            berr_q <= 1'b1;
          end else if (!ack_hit) begin
            if (tmo_hit) tmo_q <= 1'b1;
            else         cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          if (!we_q) acc_q <= acc_next;
          op_q   <= op_next;
          addr_q <= addr_next;
          rem_q  <= rem_next;
        end
        default: ;
      endcase
    end
  end

  // Output mapping; write data is only presented while the bus is driven
  always_comb begin
    BUSY        = busy_c;
    DONE        = done_c;
    RDATA       = acc_q;
    ERR_BERR    = berr_q;
    ERR_TIMEOUT = tmo_q;
    ADDR        = addr_q;
    RW          = rw_c;
    SIZ1        = rem_q[1];
    SIZ0        = rem_q[0];
    AS_n        = as_n_c;
    DS_n        = ds_n_c;
    DATA_OE     = oe_c;
    DATA_OUT    = oe_c ? wr_lanes : 32'd0;
  end

endmodule

// File: tb/tb_bus_master_030.sv
// ---------------------------------------------------------------------------
// tb_bus_master_030
//
// Directed bench for bus_master_030. A behavioural responder answers bus
// cycles as a 32-, 16- or 8-bit port, as a silent port, or with BERR on a
// chosen cycle. Expected bus cycles and expected transfer results are queued
// when a request is issued and are popped when the DUT presents a cycle or
// pulses DONE.
// ---------------------------------------------------------------------------
module tb_bus_master_030;

  localparam int ADDR_W         = 28;
  localparam int TIMEOUT_CYCLES = 255;

  localparam int PORT32 = 0;
  localparam int PORT16 = 1;
  localparam int PORT8  = 2;
  localparam int SILENT = 3;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              REQ;
  logic              REQ_WE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [1:0]        REQ_LEN;
  logic [31:0]       REQ_WDATA;
  logic              BUSY;
  logic              DONE;
  logic [31:0]       RDATA;
  logic              ERR_BERR;
  logic              ERR_TIMEOUT;
  logic [ADDR_W-1:0] ADDR;
  logic              RW;
  logic              SIZ0;
  logic              SIZ1;
  logic              AS_n;
  logic              DS_n;
  logic [31:0]       DATA_OUT;
  logic              DATA_OE;
  logic [31:0]       DATA_IN;
  logic              DSACK0_n;
  logic              DSACK1_n;
  logic              BERR_n;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        siz;
    logic              rw;
    logic [31:0]       mask;
    logic [31:0]       wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        berr;
    logic        tmo;
  } res_exp_t;

  bus_exp_t    bus_q[$];
  res_exp_t    res_q[$];
  logic [31:0] rd_q[$];
  bus_exp_t    cur_bus;

  int checks = 0;
  int fails  = 0;
  int port_mode   = PORT32;
  int berr_cycle  = 0;
  int cycle_idx   = 0;
  int done_pulses = 0;
  int lat;
  int done_before;
  logic active = 1'b0;

  bus_master_030 #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .REQ         (REQ),
    .REQ_WE      (REQ_WE),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_LEN     (REQ_LEN),
    .REQ_WDATA   (REQ_WDATA),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .RDATA       (RDATA),
    .ERR_BERR    (ERR_BERR),
    .ERR_TIMEOUT (ERR_TIMEOUT),
    .ADDR        (ADDR),
    .RW          (RW),
    .SIZ0        (SIZ0),
    .SIZ1        (SIZ1),
    .AS_n        (AS_n),
    .DS_n        (DS_n),
    .DATA_OUT    (DATA_OUT),
    .DATA_OE     (DATA_OE),
    .DATA_IN     (DATA_IN),
    .DSACK0_n    (DSACK0_n),
    .DSACK1_n    (DSACK1_n),
    .BERR_n      (BERR_n)
  );

  always #5 CLK = ~CLK;

  // Every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectBus(input logic [ADDR_W-1:0] addr, input logic [1:0] siz,
                           input logic rw, input logic [31:0] mask,
                           input logic [31:0] wdata);
    bus_exp_t e;
    e.addr  = addr;
    e.siz   = siz;
    e.rw    = rw;
    e.mask  = mask;
    e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  task automatic expectResult(input logic [31:0] rdata, input logic chk_rdata,
                              input logic berr, input logic tmo);
    res_exp_t r;
    r.rdata     = rdata;
    r.chk_rdata = chk_rdata;
    r.berr      = berr;
    r.tmo       = tmo;
    res_q.push_back(r);
  endtask

  // Present one request for a single clock and confirm it was taken
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [1:0] len, input logic [31:0] wdata);
    cycle_idx = 0;
    @(negedge CLK);
    REQ       = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    REQ_LEN   = len;
    REQ_WDATA = wdata;
    @(negedge CLK);
    REQ = 1'b0;
    checkOutput("busy_after_accept", 32'(BUSY), 32'd1);
  endtask

  // Bounded wait for DONE, then score the result against the queue
  task automatic waitDone(input int limit, output int latency);
    res_exp_t r;
    latency = 0;
    while (DONE !== 1'b1 && latency < limit) begin
      @(negedge CLK);
      latency++;
    end
    checkOutput("done_seen", 32'(DONE), 32'd1);
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      if (DONE === 1'b1) begin
        if (r.chk_rdata) checkOutput("rdata", RDATA, r.rdata);
        checkOutput("err_berr", 32'(ERR_BERR), 32'(r.berr));
        checkOutput("err_timeout", 32'(ERR_TIMEOUT), 32'(r.tmo));
        checkOutput("busy_at_done", 32'(BUSY), 32'd0);
        checkOutput("as_n_at_done", 32'(AS_n), 32'd1);
        checkOutput("ds_n_at_done", 32'(DS_n), 32'd1);
      end
    end
    checkOutput("bus_cycles_consumed", 32'(bus_q.size()), 32'd0);
    @(negedge CLK);
    checkOutput("done_one_clock", 32'(DONE), 32'd0);
    rd_q.delete();
    bus_q.delete();
  endtask

  task automatic checkResetValues(input string where);
    checkOutput({where, "_as_n"},  32'(AS_n), 32'd1);
    checkOutput({where, "_ds_n"},  32'(DS_n), 32'd1);
    checkOutput({where, "_rw"},    32'(RW), 32'd1);
    checkOutput({where, "_oe"},    32'(DATA_OE), 32'd0);
    checkOutput({where, "_busy"},  32'(BUSY), 32'd0);
    checkOutput({where, "_done"},  32'(DONE), 32'd0);
    checkOutput({where, "_berr"},  32'(ERR_BERR), 32'd0);
    checkOutput({where, "_tmo"},   32'(ERR_TIMEOUT), 32'd0);
    checkOutput({where, "_addr"},  32'(ADDR), 32'd0);
    checkOutput({where, "_siz"},   {30'd0, SIZ1, SIZ0}, 32'd0);
    checkOutput({where, "_dout"},  DATA_OUT, 32'd0);
    checkOutput({where, "_rdata"}, RDATA, 32'd0);
  endtask

  // Responder: on the first clock both strobes are low, score the cycle
  // against the expectation queue, drive read data and terminate according
  // to the configured port behaviour. Everything is released once AS_n rises.
  always @(negedge CLK) begin
    if (RST_n !== 1'b1 || AS_n !== 1'b0) begin
      DSACK0_n = 1'b1;
      DSACK1_n = 1'b1;
      BERR_n   = 1'b1;
      active   = 1'b0;
    end else if (DS_n === 1'b0 && !active) begin
      active = 1'b1;
      cycle_idx++;
      checkOutput("bus_cycle_expected", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() != 0) begin
        cur_bus = bus_q.pop_front();
        checkOutput("bus_addr", 32'(ADDR), 32'(cur_bus.addr));
        checkOutput("bus_siz", {30'd0, SIZ1, SIZ0}, {30'd0, cur_bus.siz});
        checkOutput("bus_rw", 32'(RW), 32'(cur_bus.rw));
        checkOutput("bus_data_oe", 32'(DATA_OE), 32'(!cur_bus.rw));
        if (!cur_bus.rw)
          checkOutput("bus_wdata", DATA_OUT & cur_bus.mask, cur_bus.wdata & cur_bus.mask);
      end
      if (rd_q.size() != 0) DATA_IN = rd_q.pop_front();
      else                  DATA_IN = 32'd0;
      if (cycle_idx == berr_cycle) begin
        BERR_n = 1'b0;
      end else begin
        case (port_mode)
          PORT32: begin DSACK0_n = 1'b0; DSACK1_n = 1'b0; end
          PORT16: DSACK1_n = 1'b0;
          PORT8:  DSACK0_n = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_pulses++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_n     = 1'b0;
    REQ       = 1'b0;
    REQ_WE    = 1'b0;
    REQ_ADDR  = '0;
    REQ_LEN   = 2'b00;
    REQ_WDATA = 32'd0;
    DATA_IN   = 32'd0;
    DSACK0_n  = 1'b1;
    DSACK1_n  = 1'b1;
    BERR_n    = 1'b1;

    repeat (3) @(negedge CLK);
    $display("[TB] checking reset values");
    checkResetValues("reset");
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] aligned long read, 32-bit port");
    port_mode = PORT32; berr_cycle = 0;
    expectBus(28'h0001000, 2'b00, 1'b1, 32'd0, 32'd0);
    rd_q.push_back(32'hDEADBEEF);
    expectResult(32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 28'h0001000, 2'b00, 32'd0);
    waitDone(100, lat);
    checkOutput("min_latency", 32'(lat), 32'd8);

    $display("[TB] long write, 16-bit port");
    port_mode = PORT16;
    expectBus(28'h0000100, 2'b00, 1'b0, 32'hFFFF0000, 32'h11220000);
    expectBus(28'h0000102, 2'b10, 1'b0, 32'hFFFF0000, 32'h33440000);
    expectResult(32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 28'h0000100, 2'b00, 32'h11223344);
    waitDone(100, lat);

    $display("[TB] misaligned long read, 8-bit port");
    port_mode = PORT8;
    expectBus(28'h0000201, 2'b00, 1'b1, 32'd0, 32'd0);
    expectBus(28'h0000202, 2'b11, 1'b1, 32'd0, 32'd0);
    expectBus(28'h0000203, 2'b10, 1'b1, 32'd0, 32'd0);
    expectBus(28'h0000204, 2'b01, 1'b1, 32'd0, 32'd0);
    rd_q.push_back(32'hA1000000);
    rd_q.push_back(32'hB2000000);
    rd_q.push_back(32'hC3000000);
    rd_q.push_back(32'hD4000000);
    expectResult(32'hA1B2C3D4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 28'h0000201, 2'b00, 32'd0);
    waitDone(200, lat);

    $display("[TB] byte write at offset 3, 32-bit port");
    port_mode = PORT32;
    expectBus(28'h0000003, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h5A5A5A5A);
    expectResult(32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 28'h0000003, 2'b01, 32'h0000005A);
    waitDone(100, lat);

    $display("[TB] long read at offset 2, 32-bit port");
    port_mode = PORT32;
    expectBus(28'h0000002, 2'b00, 1'b1, 32'd0, 32'd0);
    expectBus(28'h0000004, 2'b10, 1'b1, 32'd0, 32'd0);
    rd_q.push_back(32'h00001122);
    rd_q.push_back(32'h33440000);
    expectResult(32'h11223344, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 28'h0000002, 2'b00, 32'd0);
    waitDone(100, lat);

    $display("[TB] word read, 16-bit port");
    port_mode = PORT16;
    expectBus(28'h0000402, 2'b10, 1'b1, 32'd0, 32'd0);
    rd_q.push_back(32'hBEEF1234);
    expectResult(32'h0000BEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 28'h0000402, 2'b10, 32'd0);
    waitDone(100, lat);

    $display("[TB] silent responder, expect timeout");
    port_mode = SILENT;
    expectBus(28'h0000400, 2'b00, 1'b1, 32'd0, 32'd0);
    expectResult(32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 28'h0000400, 2'b00, 32'd0);
    waitDone(TIMEOUT_CYCLES + 100, lat);
    checkOutput("timeout_latency_window",
                32'(lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + 4), 32'd1);

    $display("[TB] normal write after timeout");
    port_mode = PORT32;
    expectBus(28'h0000010, 2'b00, 1'b0, 32'hFFFFFFFF, 32'hCAFEF00D);
    expectResult(32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 28'h0000010, 2'b00, 32'hCAFEF00D);
    waitDone(100, lat);

    $display("[TB] bus error on second cycle of split read");
    port_mode = PORT8; berr_cycle = 2;
    expectBus(28'h0000000, 2'b00, 1'b1, 32'd0, 32'd0);
    expectBus(28'h0000001, 2'b11, 1'b1, 32'd0, 32'd0);
    rd_q.push_back(32'h77000000);
    rd_q.push_back(32'h88000000);
    expectResult(32'h00000077, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 28'h0000000, 2'b00, 32'd0);
    waitDone(200, lat);
    repeat (10) @(negedge CLK);
    checkOutput("no_cycle_after_berr", 32'(cycle_idx), 32'd2);
    berr_cycle = 0;

    $display("[TB] reset during WAIT");
    port_mode = SILENT;
    expectBus(28'h0000300, 2'b00, 1'b1, 32'd0, 32'd0);
    applyStimulus(1'b0, 28'h0000300, 2'b00, 32'd0);
    lat = 0;
    while (AS_n !== 1'b0 && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    checkOutput("as_asserted_before_reset", 32'(AS_n), 32'd0);
    repeat (3) @(negedge CLK);
    done_before = done_pulses;
    RST_n = 1'b0;
    @(negedge CLK);
    checkResetValues("midreset");
    RST_n = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("no_done_after_reset", 32'(done_pulses - done_before), 32'd0);
    checkOutput("idle_after_reset", 32'(BUSY), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
